// File: rtl/pwm_pkg.sv
// ============================================================================
// pwm_pkg : shared types and defaults for the PWM capture block
// Rev 1.0
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int PWM_CAP_WIDTH_DEFAULT = 9;

    typedef enum logic [1:0] {
        PWM_CAP_IDLE = 2'b00,
        PWM_CAP_HIGH = 2'b01,
        PWM_CAP_LOW  = 2'b10
    } pwm_cap_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_sync.sv
// ============================================================================
// pwm_sync : 2-FF synchronizer with edge detection for an asynchronous pin
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic s2,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign s2   = s2_q;
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// pwm_capture : measures high time and rise-to-rise period of a PWM input,
//               flags a stuck input as timeout with the stuck level
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_CAP_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] duty_out,
    output logic [WIDTH-1:0] period_out,
    output logic             valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic s2, rise, fall;

    pwm_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (pwm_in),
        .s2    (s2),
        .rise  (rise),
        .fall  (fall)
    );

    pwm_cap_state_t   state_q, state_d;
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [WIDTH-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             level_q, level_d;
    logic [WIDTH-1:0] pcnt_inc;

    assign pcnt_inc = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        pcnt_d    = pcnt_q;
        duty_d    = duty_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        level_d   = level_q;

        if (!en) begin
            state_d = PWM_CAP_IDLE;
            hcnt_d  = '0;
            pcnt_d  = '0;
        end else if (rise) begin
            // A rise wins over a saturated period counter in the same cycle.
            if (state_q == PWM_CAP_LOW) begin
                duty_d    = hcnt_q;
                period_d  = pcnt_q;
                valid_d   = 1'b1;
                timeout_d = 1'b0;
            end
            hcnt_d  = WIDTH'(1);
            pcnt_d  = WIDTH'(1);
            state_d = PWM_CAP_HIGH;
        end else if (pcnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            level_d   = s2;
            state_d   = PWM_CAP_IDLE;
        end else begin
            case (state_q)
                PWM_CAP_IDLE: begin
                    pcnt_d = pcnt_inc;
                end
                PWM_CAP_HIGH: begin
                    pcnt_d = pcnt_inc;
                    if (fall) begin
                        state_d = PWM_CAP_LOW;
                    end else begin
                        hcnt_d = hcnt_q + WIDTH'(1);
                    end
                end
                PWM_CAP_LOW: begin
                    pcnt_d = pcnt_inc;
                end
                default: begin
                    state_d = PWM_CAP_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PWM_CAP_IDLE;
            hcnt_q    <= '0;
            pcnt_q    <= '0;
            duty_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            pcnt_q    <= pcnt_d;
            duty_q    <= duty_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            level_q   <= level_d;
        end
    end

    assign duty_out   = duty_q;
    assign period_out = period_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;
    assign level      = level_q;

endmodule

`default_nettype wire

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform. For each full cycle of `pwm_in` it reports the high time (`duty_out`) and the rise-to-rise period (`period_out`), both in `clk` cycles. It is the receive-side counterpart of the design's PWM generator, and the two are used together for loopback self-test on the Tiny Tapeout user pins. It also reports a constant (edge-free) input as a timeout, together with the stuck level.

## Interface
- `WIDTH`, default 9: counter and output width. The largest measurable period is 2^WIDTH-1 cycles. The default of 9 covers the period of an 8-bit generator.

- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: capture enable.
- `pwm_in` in 1: asynchronous PWM input.
- `duty_out` out WIDTH: high cycles of the last complete period.
- `period_out` out WIDTH: rise-to-rise cycles of the last complete period.
- `valid` out 1: one-cycle pulse when `duty_out`/`period_out` update.
- `timeout` out 1: no rising edge was seen within 2^WIDTH-1 cycles.
- `level` out 1: synchronized `pwm_in` value latched when `timeout` set.

## Operation
- **Synchronizer:** `pwm_in` → `s1` → `s2` (2-FF); `s3` holds the previous `s2`.
  - `rise` = `s2 & ~s3`
  - `fall` = `~s2 & s3`
- **Counters:** `hcnt` and `pcnt`, each WIDTH bits, unsigned.
- **States:** IDLE, HIGH, LOW.
- **IDLE**
  - `pcnt` increments each cycle, saturating.
  - On `rise`: `hcnt`=1, `pcnt`=1, go to HIGH. No `valid` is produced; the first edge only arms the measurement.
- **HIGH**
  - `pcnt`++ every cycle; `hcnt`++ every cycle without `fall`.
  - On `fall`: go to LOW.
- **LOW**
  - `pcnt`++ every cycle.
  - On `rise`: `duty_out`←`hcnt`, `period_out`←`pcnt`, `valid`=1, `timeout`←0, `hcnt`=1, `pcnt`=1, stay measuring (go to HIGH).
- **Timeout:** if `pcnt` = 2^WIDTH-1 and no `rise` occurs that cycle, in any state:
  - `timeout`←1, `level`←`s2`, go to IDLE.
  - `duty_out`/`period_out` keep their previous values.
  - `pcnt` holds saturated.
  - `timeout` stays set until the next `valid`.
- **Simultaneous events:** `rise` in the same cycle as `pcnt` reaching max counts as a rise. The measurement is latched (`period_out`=2^WIDTH-1) and no timeout occurs.
- **`en` low:**
  - FSM is forced to IDLE; `hcnt`=0, `pcnt`=0.
  - Outputs hold; `valid`=0.
  - The synchronizer keeps running.
  - When `en` is raised again, the next `rise` arms the measurement and `valid` needs a second rise.
- **Reset:** asynchronous; all registers clear.
  - Outputs: `duty_out`=0, `period_out`=0, `valid`=0, `timeout`=0, `level`=0.
  - State is IDLE; `s1`/`s2`/`s3`=0.
  - Reset mid-measurement discards the partial counts.

## Timing
- `pwm_in` first sampled high at edge k:
  - `s2`=1 after edge k+1.
  - The rise is registered at edge k+2.
  - `valid` is high during the cycle after edge k+2.
- Fixed latency is 2 cycles from pin to measurement. Because both edges are delayed equally, the reported duty and period are unaffected.
- `valid` is exactly 1 cycle wide. Back-to-back periods of ≥2 cycles give one pulse per period.
- Minimum resolvable pulses: high ≥1 cycle, low ≥1 cycle (period ≥2). Narrower glitches may be lost by the synchronizer.

## Structure
- **Shared package `pwm_pkg`:**
  - state typedef `pwm_cap_state_t`, with IDLE=2'b00, HIGH=2'b01, LOW=2'b10. Other encodings go to IDLE.
  - `PWM_CAP_WIDTH_DEFAULT`=9.
- **Sub-module `pwm_sync`:** 2-FF synchronizer plus the previous-value register. Outputs `s2`, `rise`, `fall`. It is reused for other async pins.
- FSM, counters and output registers live in `pwm_capture`.

## Test plan
- Repeating 64 high / 192 low after reset, `en`=1 → no `valid` on the first rise. At every subsequent rise: `duty_out`=64, `period_out`=256, one-cycle `valid`.
- 1 high / 9 low → `duty_out`=1, `period_out`=10, `valid` every 10 cycles.
- `pwm_in` held 0 (then separately held 1) for 600 cycles after reset → `timeout`=1 at cycle 511 after reset release, `level`=0 (then 1). No `valid`; outputs stay 0.
- Valid stream (64/256), then `pwm_in` stuck high → `timeout`=1, `level`=1, `duty_out`/`period_out` stay 64/256. On resuming the stream, the first rise re-arms and the next rise gives `valid` with `timeout`=0.
- `rst_n` pulsed low mid-HIGH, asynchronously between edges → outputs 0 immediately, FSM in IDLE. The next `valid` arrives only at the second rise after release, with correct values.
- `en` dropped for 50 cycles mid-stream → no `valid` while low, outputs hold. After `en` rises, the first rise arms and the second produces correct values.
